// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: FSM state encoding
// and destination-address constants.
package router_pkg;

    // Fixed 3-bit encodings; other router blocks and debug probes rely on
    // these exact values.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

    // Header address that no output port answers to; such packets are dropped.
    localparam logic [1:0] ROUTER_ADDR_INVALID = 2'd3;

    localparam int ROUTER_NUM_PORTS = 3;

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, waits for the selected
// destination FIFO to drain, then sequences the byte register through
// header, payload, full-stall and parity phases. All outputs are Moore
// decodes of the state register.
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_INVALID = ADDR_W'(ROUTER_ADDR_INVALID);

    router_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [ROUTER_NUM_PORTS-1:0] empty_vec;
    logic [ROUTER_NUM_PORTS-1:0] soft_vec;
    logic                        hdr_empty;   // empty flag of the port named by data_in
    logic                        sel_empty;   // empty flag of the latched port
    logic                        sel_soft;    // soft reset of the latched port
    logic                        hdr_valid;

    assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_valid = pkt_valid && (data_in != ADDR_INVALID);

    // Select one per-port flag by address; the invalid address selects nothing.
    function automatic logic pick_port(input logic [ADDR_W-1:0] a,
                                       input logic [ROUTER_NUM_PORTS-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < ROUTER_NUM_PORTS; i++) begin
            if (a == ADDR_W'(i)) r = v[i];
        end
        return r;
    endfunction

    // 3:1 muxes of the destination status flags.
    always_comb begin
        hdr_empty = pick_port(data_in, empty_vec);
        sel_empty = pick_port(addr_q, empty_vec);
        sel_soft  = pick_port(addr_q, soft_vec);
    end

    // State and latched-address registers.
    always_ff @(posedge clock) begin
        // NOTE: resetn is sampled on the clock edge (synchronous), so it is
        // absent from the sensitivity list; state uses <= so every flop sees
        // pre-edge values.
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and address-capture logic.
    always_comb begin
        // NOTE: defaults first so every path assigns state_d/addr_d and no
        // latch is inferred.
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_valid) begin
                    addr_d  = data_in;
                    state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                // A full FIFO wins over the end of the payload.
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A timeout on the active destination aborts the packet from any phase.
        if ((state_q != DECODE_ADDRESS) && sel_soft) state_d = DECODE_ADDRESS;
    end

    // Moore output decodes.
    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
    assign busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed steps from the test plan followed by random
// stimulus, all checked against a phase-level reference model whose phases
// are the expected output strobe patterns themselves.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    router_fsm #(.ADDR_W(2)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .write_enb_reg(write_enb_reg),
        .busy         (busy)
    );

    // Output patterns {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy};
    // the model tracks the phase as one of these patterns.
    localparam logic [7:0] V_IDLE = 8'b1000_0000;
    localparam logic [7:0] V_LFD  = 8'b0100_0001;
    localparam logic [7:0] V_LD   = 8'b0010_0010;
    localparam logic [7:0] V_LAF  = 8'b0001_0011;
    localparam logic [7:0] V_FULL = 8'b0000_1001;
    localparam logic [7:0] V_CPE  = 8'b0000_0101;
    localparam logic [7:0] V_LP   = 8'b0000_0011;
    localparam logic [7:0] V_WAIT = 8'b0000_0001;

    logic [7:0] m_phase;
    logic [1:0] m_addr;

    function automatic logic empty_of(input logic [1:0] a);
        return (a == 2'd0) ? fifo_empty_0 : (a == 2'd1) ? fifo_empty_1 :
               (a == 2'd2) ? fifo_empty_2 : 1'b0;
    endfunction

    function automatic logic soft_of(input logic [1:0] a);
        return (a == 2'd0) ? soft_reset_0 : (a == 2'd1) ? soft_reset_1 :
               (a == 2'd2) ? soft_reset_2 : 1'b0;
    endfunction

    function automatic logic [7:0] dut_vec();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge,
    // then compare outputs and latched address 1 time unit later.
    task automatic step(input string tag);
        logic [7:0] nxt;
        @(posedge clock);
        if (!resetn) begin
            nxt    = V_IDLE;
            m_addr = 2'd0;
        end else if (m_phase != V_IDLE && soft_of(m_addr)) begin
            nxt = V_IDLE;
        end else begin
            nxt = m_phase;
            if (m_phase == V_IDLE) begin
                if (pkt_valid && data_in != 2'd3) begin
                    nxt    = empty_of(data_in) ? V_LFD : V_WAIT;
                    m_addr = data_in;
                end
            end else if (m_phase == V_WAIT) begin
                if (empty_of(m_addr)) nxt = V_LFD;
            end else if (m_phase == V_LFD) begin
                nxt = V_LD;
            end else if (m_phase == V_LD) begin
                if (fifo_full)       nxt = V_FULL;
                else if (!pkt_valid) nxt = V_LP;
            end else if (m_phase == V_FULL) begin
                if (!fifo_full) nxt = V_LAF;
            end else if (m_phase == V_LAF) begin
                nxt = parity_done ? V_IDLE : (low_pkt_valid ? V_LP : V_LD);
            end else if (m_phase == V_LP) begin
                nxt = V_CPE;
            end else if (m_phase == V_CPE) begin
                nxt = fifo_full ? V_FULL : V_IDLE;
            end
        end
        m_phase = nxt;
        #1;
        check({tag, "/outputs"}, dut_vec(), m_phase);
        check({tag, "/addr"}, {6'd0, dut.addr_q}, {6'd0, m_addr});
    endtask

    int rst_int_pulses;

    initial begin
        m_phase = V_IDLE;
        m_addr  = 2'd0;
        resetn = 1'b0; pkt_valid = 1'b1; data_in = 2'd1; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // Reset held two cycles with pkt_valid high.
        step("reset0");
        step("reset1");
        check("reset_lit", dut_vec(), V_IDLE);

        // Normal packet to port 1, three payload bytes then parity.
        resetn = 1'b1; pkt_valid = 1'b1; data_in = 2'd1;
        step("norm_hdr");       check("norm_lfd", dut_vec(), V_LFD);
        data_in = 2'd0;
        step("norm_ld1");       check("norm_ld1_lit", dut_vec(), V_LD);
        step("norm_ld2");
        step("norm_ld3");
        step("norm_ld4");       check("norm_ld4_lit", dut_vec(), V_LD);
        pkt_valid = 1'b0;
        step("norm_lp");        check("norm_lp_lit", dut_vec(), V_LP);
        rst_int_pulses = 0;
        step("norm_cpe");       check("norm_cpe_lit", dut_vec(), V_CPE);
        rst_int_pulses += int'(rst_int_reg);
        step("norm_done");      check("norm_done_lit", dut_vec(), V_IDLE);
        rst_int_pulses += int'(rst_int_reg);
        check("norm_rst_int_once", 8'(rst_int_pulses), 8'd1);

        // Busy destination: port 2 not empty for five cycles.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        step("busy_hdr");       check("busy_wait_lit", dut_vec(), V_WAIT);
        pkt_valid = 1'b0; data_in = 2'd0;
        for (int i = 0; i < 4; i++) step("busy_wait");
        check("busy_wait5_lit", dut_vec(), V_WAIT);
        fifo_empty_2 = 1'b1;
        step("busy_lfd");       check("busy_lfd_lit", dut_vec(), V_LFD);
        pkt_valid = 1'b1;
        step("stall_ld");

        // Full stall for three cycles, then low_pkt_valid leads to parity.
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step("stall_full");
        check("stall_full_lit", dut_vec(), V_FULL);
        fifo_full = 1'b0;
        step("stall_laf");      check("stall_laf_lit", dut_vec(), V_LAF);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step("stall_lp");       check("stall_lp_lit", dut_vec(), V_LP);
        low_pkt_valid = 1'b0;
        step("stall_cpe");
        step("stall_idle");

        // Same stall, this time parity already captured.
        pkt_valid = 1'b1; data_in = 2'd2;
        step("pd_hdr");
        step("pd_ld");
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step("pd_full");
        fifo_full = 1'b0;
        step("pd_laf");
        parity_done = 1'b1;
        step("pd_idle");        check("pd_idle_lit", dut_vec(), V_IDLE);
        parity_done = 1'b0;

        // Soft reset on a packet to port 0: only soft_reset_0 matters.
        pkt_valid = 1'b1; data_in = 2'd0;
        step("sr_hdr");
        step("sr_ld");
        soft_reset_1 = 1'b1;
        step("sr_other");       check("sr_other_lit", dut_vec(), V_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step("sr_sel");         check("sr_sel_lit", dut_vec(), V_IDLE);
        soft_reset_0 = 1'b0;

        // Invalid address held four cycles.
        data_in = 2'd3; pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) step("inv_addr");
        check("inv_addr_lit", dut_vec(), V_IDLE);
        check("inv_addr_q", {6'd0, dut.addr_q}, 8'd0);

        // Reset mid-packet.
        data_in = 2'd1;
        step("mid_hdr");
        step("mid_ld");
        resetn = 1'b0;
        step("mid_reset");      check("mid_reset_lit", dut_vec(), V_IDLE);
        resetn = 1'b1;

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            resetn        = ($urandom_range(0, 49) != 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty_0  = ($urandom_range(0, 2) != 0);
            fifo_empty_1  = ($urandom_range(0, 2) != 0);
            fifo_empty_2  = ($urandom_range(0, 2) != 0);
            soft_reset_0  = ($urandom_range(0, 19) == 0);
            soft_reset_1  = ($urandom_range(0, 19) == 0);
            soft_reset_2  = ($urandom_range(0, 19) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 2) == 0);
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
